reset_sequencer: RTL and testbench

Consumes the synchronized reset produced by the reset synchronizer stage and turns it into an ordered set of per-subsystem active-low resets. Outputs release one at a time, starting only after a minimum assertion time and a clock-lock qualifier, with a fixed gap between stages. A software reset request or loss of lock restarts the whole sequence. It sits directly after the synchronizer, in the same clock domain, and drives the resets of the downstream logic blocks.

---
 rtl/reset_sequencer.sv | 123 ++++++++++++
 tb/tb_reset_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Reset release sequencer: holds all per-subsystem resets for a minimum time, waits
// for clock lock, then releases stages one at a time with a fixed gap between them.
module reset_sequencer #(
   parameter int unsigned NUM_STAGES  = 4,
   parameter int unsigned MIN_ASSERT  = 8,
   parameter int unsigned STAGE_DELAY = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sw_rst_req,
   input  logic                  pll_locked,
   output logic [NUM_STAGES-1:0] stage_rst_n,
   output logic                  busy,
   output logic                  done,
   output logic [7:0]            restart_cnt
);

   localparam int unsigned MAX_CNT = (MIN_ASSERT > STAGE_DELAY) ? MIN_ASSERT : STAGE_DELAY;
   localparam int unsigned CW      = $clog2(MAX_CNT + 1);

   typedef enum logic [1:0] {
      HOLD,
      WAIT_LOCK,
      RELEASE,
      DONE
   } state_e;

   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [NUM_STAGES-1:0] stage_d;
   logic                  busy_d;
   logic                  done_d;
   logic [7:0]            restart_cnt_d;

   // State, counter and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= HOLD;
         cnt_q       <= '0;
         stage_rst_n <= '0;
         busy        <= 1'b1;
         done        <= 1'b0;
         restart_cnt <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stage_rst_n <= stage_d;
         busy        <= busy_d;
         done        <= done_d;
         restart_cnt <= restart_cnt_d;
      end
   end

   // Next-state and next-output logic; restart causes override the normal sequence
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      stage_d       = stage_rst_n;
      done_d        = 1'b0;
      restart_cnt_d = restart_cnt;

      case (state_q)
         HOLD: begin
            if (cnt_q == CW'(MIN_ASSERT - 1)) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         WAIT_LOCK: begin
            if (pll_locked) begin
               stage_d = NUM_STAGES'(1);
               cnt_d   = '0;
               if (NUM_STAGES == 1) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = RELEASE;
               end
            end
         end
         RELEASE: begin
            if (cnt_q == CW'(STAGE_DELAY - 1)) begin
               // Shift in one more released bit, keeping the thermometer pattern
               stage_d = NUM_STAGES'({stage_rst_n, 1'b1});
               cnt_d   = '0;
               if (stage_d[NUM_STAGES-1]) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
         end
         default: begin
            state_d = HOLD;
            cnt_d   = '0;
            stage_d = '0;
         end
      endcase

      if (sw_rst_req) begin
         state_d = HOLD;
         cnt_d   = '0;
         stage_d = '0;
         done_d  = 1'b0;
      end else if (!pll_locked && (state_q == RELEASE || state_q == DONE)) begin
         state_d = HOLD;
         cnt_d   = '0;
         stage_d = '0;
         done_d  = 1'b0;
         if (restart_cnt != 8'hFF) begin
            restart_cnt_d = restart_cnt + 8'd1;
         end
      end

      busy_d = ~&stage_d;
   end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default configuration plus a minimal
// single-stage instance; all expected values are hand-derived edge numbers.
module tb_reset_sequencer;

   logic       clk;
   logic       rst_n, sw_rst_req, pll_locked;
   logic [3:0] stage_rst_n;
   logic       busy, done;
   logic [7:0] restart_cnt;

   logic       rst2_n, sw2, lock2;
   logic [0:0] stage2;
   logic       busy2, done2;
   logic [7:0] rc2;

   int checks = 0;
   int errors = 0;
   int cur    = 0;

   reset_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sw_rst_req (sw_rst_req),
      .pll_locked (pll_locked),
      .stage_rst_n(stage_rst_n),
      .busy       (busy),
      .done       (done),
      .restart_cnt(restart_cnt)
   );

   reset_sequencer #(.NUM_STAGES(1), .MIN_ASSERT(1), .STAGE_DELAY(1)) dut1 (
      .clk        (clk),
      .rst_n      (rst2_n),
      .sw_rst_req (sw2),
      .pll_locked (lock2),
      .stage_rst_n(stage2),
      .busy       (busy2),
      .done       (done2),
      .restart_cnt(rc2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cur++;
   endtask

   task automatic go_to(input int n);
      while (cur < n) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s at edge +%0d: observed %0h expected %0h", tag, cur, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] st, input logic bz,
                          input logic dn, input logic [7:0] rc);
      chk({tag, ".stage"}, 32'(stage_rst_n), 32'(st));
      chk({tag, ".busy"},  32'(busy),        32'(bz));
      chk({tag, ".done"},  32'(done),        32'(dn));
      chk({tag, ".rcnt"},  32'(restart_cnt), 32'(rc));
   endtask

   initial begin
      rst_n = 1'b0; sw_rst_req = 1'b0; pll_locked = 1'b1;
      rst2_n = 1'b0; sw2 = 1'b0; lock2 = 1'b1;

      // Nominal release sequence with lock present
      tick(); tick();
      cur = 0;
      chk_all("reset", 4'h0, 1'b1, 1'b0, 8'd0);
      rst_n = 1'b1;
      go_to(8);  chk_all("nom_e8",  4'h0, 1'b1, 1'b0, 8'd0);
      go_to(9);  chk_all("nom_e9",  4'h1, 1'b1, 1'b0, 8'd0);
      go_to(24); chk("nom_e24", 32'(stage_rst_n), 32'h1);
      go_to(25); chk("nom_e25", 32'(stage_rst_n), 32'h3);
      go_to(41); chk("nom_e41", 32'(stage_rst_n), 32'h7);
      go_to(56); chk_all("nom_e56", 4'h7, 1'b1, 1'b0, 8'd0);
      go_to(57); chk_all("nom_e57", 4'hF, 1'b0, 1'b1, 8'd0);
      go_to(58); chk_all("nom_e58", 4'hF, 1'b0, 1'b0, 8'd0);

      // Late lock: first sampled high at edge e+30
      rst_n = 1'b0; pll_locked = 1'b0;
      tick(); cur = 0;
      rst_n = 1'b1;
      go_to(29); chk_all("late_e29", 4'h0, 1'b1, 1'b0, 8'd0);
      pll_locked = 1'b1;
      go_to(30); chk("late_e30", 32'(stage_rst_n), 32'h1);
      go_to(77); chk("late_e77", 32'(stage_rst_n), 32'h7);
      go_to(78); chk_all("late_e78", 4'hF, 1'b0, 1'b1, 8'd0);

      // Lock loss in DONE at edge d
      go_to(80);
      pll_locked = 1'b0;
      tick(); cur = 0;
      pll_locked = 1'b1;
      chk_all("lockloss_d", 4'h0, 1'b1, 1'b0, 8'd1);
      go_to(8);  chk("lockloss_d8", 32'(stage_rst_n), 32'h0);
      go_to(9);  chk("lockloss_d9", 32'(stage_rst_n), 32'h1);

      // Software reset mid-RELEASE at edge s
      go_to(30); chk("sw_pre", 32'(stage_rst_n), 32'h3);
      sw_rst_req = 1'b1;
      tick(); cur = 0;
      sw_rst_req = 1'b0;
      chk_all("sw_s", 4'h0, 1'b1, 1'b0, 8'd1);
      go_to(8);  chk("sw_s8", 32'(stage_rst_n), 32'h0);
      go_to(9);  chk("sw_s9", 32'(stage_rst_n), 32'h1);

      // Software reset and lock loss on the same edge
      go_to(12);
      sw_rst_req = 1'b1; pll_locked = 1'b0;
      tick(); cur = 0;
      sw_rst_req = 1'b0; pll_locked = 1'b1;
      chk_all("sw_and_loss", 4'h0, 1'b1, 1'b0, 8'd1);

      // Held software request keeps HOLD; timing restarts from last high sample
      go_to(5);
      sw_rst_req = 1'b1;
      go_to(20);
      sw_rst_req = 1'b0;
      cur = 0;
      go_to(8);  chk("swhold_8", 32'(stage_rst_n), 32'h0);
      go_to(9);  chk("swhold_9", 32'(stage_rst_n), 32'h1);

      // Repeated lock-loss restarts saturate the counter
      for (int i = 1; i <= 300; i++) begin
         go_to(9);
         pll_locked = 1'b0;
         tick(); cur = 0;
         pll_locked = 1'b1;
         if (i == 100) chk("rcnt_101", 32'(restart_cnt), 32'd101);
      end
      chk("rcnt_sat", 32'(restart_cnt), 32'd255);

      // Synchronous reset mid-sequence clears everything
      go_to(20);
      rst_n = 1'b0;
      tick(); cur = 0;
      rst_n = 1'b1;
      chk_all("rst_mid", 4'h0, 1'b1, 1'b0, 8'd0);

      // Single-stage minimal-timing instance
      tick(); cur = 0;
      chk("s1_reset", 32'({stage2, busy2, done2}), 32'b010);
      rst2_n = 1'b1;
      go_to(1); chk("s1_e1", 32'({stage2, busy2, done2}), 32'b010);
      go_to(2); chk("s1_e2", 32'({stage2, busy2, done2}), 32'b101);
      go_to(3); chk("s1_e3", 32'({stage2, busy2, done2}), 32'b100);
      chk("s1_rcnt", 32'(rc2), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
